// File: rtl/rom_responder.sv
// rom_responder: serves instruction nibbles to a nibble-bus CPU from a byte-wide external ROM.
// Latency: the address is complete at cycle 2 and mem_req is raised for cycle 3; an ack in cycle 3 returns OPR/OPA at cycles 3/4.
// Backpressure: mem_req is held until mem_ack and never withdrawn; a byte that misses its slot is dropped and fetch_late flags cycle 3.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   sync              marks the current clock as bus cycle 0
//   bus_in/bus_valid  address nibbles from the CPU during cycles 0-2
//   data_out/data_oe  OPR at cycle 3, OPA at cycle 4 (zero when the byte is not ready)
//   mem_addr/mem_req  ROM read request, held until mem_ack
//   mem_ack/mem_data  ROM acknowledge and byte ([7:4] OPR, [3:0] OPA)
//   fetch_late        one-clock pulse at cycle 3 while the ROM read is still pending
// Build option: define ROM_RESPONDER_CACHE_EN to add a one-entry cache (last acked address and byte)
// that completes a repeat fetch without touching the ROM.

module rom_responder #(
  parameter int CYCLES_PER_INST = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sync,
  input  logic [3:0]  bus_in,
  input  logic        bus_valid,
  output logic [3:0]  data_out,
  output logic        data_oe,
  output logic [11:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        fetch_late
);

  typedef enum logic [1:0] {IDLE, CAPTURE, REQ, READY} state_t;

  typedef struct packed {
    logic [3:0] opr;
    logic [3:0] opa;
  } inst_byte_t;

  localparam logic [2:0] LAST_CYC = 3'(CYCLES_PER_INST - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cyc;
  logic [7:0] addr_lo;
  logic [11:0] full_addr;
  inst_byte_t byte_q;
  inst_byte_t hit_byte;
  logic       req_live;
  logic       cap_start;
  logic       cap_mid;
  logic       cap_done;
  logic       cache_hit;
  logic       req_ack;
  logic       ack_use;

  // sync overrides the running count so this clock is cycle 0.
  assign cyc = sync ? 3'd0 : cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 3'd0;
    end else if (cyc >= LAST_CYC) begin
      cnt <= 3'd0;
    end else begin
      cnt <= cyc + 3'd1;
    end
  end

  // A new capture may begin from any state except REQ: while a ROM read is
  // outstanding the bus is ignored until the ack retires it.
  assign cap_start = (state != REQ) && (cyc == 3'd0) && bus_valid;
  assign cap_mid   = (state == CAPTURE) && (cyc == 3'd1) && bus_valid;
  assign cap_done  = (state == CAPTURE) && (cyc == 3'd2) && bus_valid;
  assign full_addr = {bus_in, addr_lo};
  assign req_ack   = (state == REQ) && mem_ack;
  // Only an ack for the current slot, arriving while its nibbles are still
  // being presented, delivers data; anything else is a stale byte.
  assign ack_use   = req_ack && req_live && ((cyc == 3'd3) || (cyc == 3'd4));

`ifdef ROM_RESPONDER_CACHE_EN
  logic        cache_vld;
  logic [11:0] cache_addr;
  inst_byte_t  cache_byte;

  always_ff @(posedge clock) begin
    if (reset) begin
      cache_vld  <= 1'b0;
      cache_addr <= 12'h000;
      cache_byte <= '0;
    end else if (req_ack) begin
      // Every ack carries the true ROM content for mem_addr, even a late one.
      cache_vld  <= 1'b1;
      cache_addr <= mem_addr;
      cache_byte <= mem_data;
    end
  end

  assign cache_hit = cache_vld && (cache_addr == full_addr);
  assign hit_byte  = cache_byte;
`else
  assign cache_hit = 1'b0;
  assign hit_byte  = '0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cap_start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (cap_start) begin
          state_nxt = CAPTURE;
        end else if (cap_done) begin
          state_nxt = cache_hit ? READY : REQ;
        end else if (!cap_mid) begin
          // bus_valid dropped, or sync restarted the slot with no valid nibble
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) state_nxt = (ack_use && (cyc == 3'd3)) ? READY : IDLE;
      end
      READY: begin
        if (cap_start) begin
          state_nxt = CAPTURE;
        end else if (cyc != 3'd3) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address assembly, request bookkeeping and byte latch
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_lo  <= 8'h00;
      mem_addr <= 12'h000;
      byte_q   <= '0;
      req_live <= 1'b0;
    end else begin
      if (cap_start) addr_lo[3:0] <= bus_in;
      if (cap_mid)   addr_lo[7:4] <= bus_in;
      if (cap_done && !cache_hit) mem_addr <= full_addr;

      if (cap_done && !cache_hit) begin
        req_live <= 1'b1;
      end else if ((state == REQ) && (mem_ack || sync || (cyc == 3'd4))) begin
        // The slot this read belongs to is over: a later ack is discarded.
        req_live <= 1'b0;
      end

      if (req_ack) begin
        byte_q <= mem_data;
      end else if (cap_done && cache_hit) begin
        byte_q <= hit_byte;
      end
    end
  end

  assign mem_req = (state == REQ);

  // Bus outputs. An ack in cycle 3 is forwarded straight to data_out so the
  // minimum-latency case returns OPR in the same clock.
  always_comb begin
    data_oe    = 1'b0;
    data_out   = 4'h0;
    fetch_late = 1'b0;
    if (!reset && ((cyc == 3'd3) || (cyc == 3'd4))) begin
      data_oe = 1'b1;
      if (state == READY) begin
        data_out = (cyc == 3'd3) ? byte_q.opr : byte_q.opa;
      end else if (ack_use) begin
        data_out = (cyc == 3'd3) ? mem_data[7:4] : mem_data[3:0];
      end else if ((state == REQ) && (cyc == 3'd3)) begin
        fetch_late = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_responder.sv
// tb_rom_responder: directed scenarios plus randomized bus/ROM traffic against a behavioural model.
// Latency: not applicable (testbench).
// Backpressure: the bench acts as the ROM and chooses ack delays, including acks that miss the slot.

module tb_rom_responder;

  localparam int CPI = 8;
`ifdef ROM_RESPONDER_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        sync;
  logic [3:0]  bus_in;
  logic        bus_valid;
  logic [3:0]  data_out;
  logic        data_oe;
  logic [11:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        fetch_late;

  rom_responder #(.CYCLES_PER_INST(CPI)) dut (
    .clock      (clock),
    .reset      (reset),
    .sync       (sync),
    .bus_in     (bus_in),
    .bus_valid  (bus_valid),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .fetch_late (fetch_late)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", tag, got, exp, $time);
    end
  endtask

  // ROM contents
  logic [7:0] rom [4096];

  // Behavioural model: slot position, capture progress, outstanding read,
  // whether that read still belongs to the current slot, and the delivered byte.
  int          m_cnt;
  bit          m_cap;
  bit          m_req;
  bit          m_live;
  bit          m_rdy;
  logic [7:0]  m_lo;
  logic [11:0] m_maddr;
  logic [7:0]  m_byte;
  bit          m_cv;
  logic [11:0] m_ca;
  logic [7:0]  m_cb;

  // ROM behaviour
  int req_age;
  int ack_delay;
  bit rand_ack;
  bit stray_ack;

  task automatic model_reset();
    m_cnt = 0; m_cap = 0; m_req = 0; m_live = 0; m_rdy = 0;
    m_lo = 8'h00; m_maddr = 12'h000; m_byte = 8'h00;
    m_cv = 0; m_ca = 12'h000; m_cb = 8'h00;
  endtask

  task automatic model_step();
    int e;
    bit was_req;
    logic [11:0] full;
    e = sync ? 0 : m_cnt;
    was_req = m_req;
    if (reset) begin
      model_reset();
    end else begin
      m_cnt = (e == CPI - 1) ? 0 : e + 1;
      if (m_req) begin
        if (mem_ack) begin
          if (m_live && e == 3) begin
            m_rdy  = 1;
            m_byte = mem_data;
          end
          m_cv = 1; m_ca = m_maddr; m_cb = mem_data;
          m_req = 0; m_live = 0;
        end else if (sync || e == 4) begin
          m_live = 0;
        end
      end else if (e == 0) begin
        m_rdy = 0;
        m_cap = bus_valid;
        if (bus_valid) m_lo[3:0] = bus_in;
      end else if (m_cap) begin
        if (!bus_valid) begin
          m_cap = 0;
        end else if (e == 1) begin
          m_lo[7:4] = bus_in;
        end else begin
          full  = {bus_in, m_lo};
          m_cap = 0;
          if (CACHE && m_cv && m_ca == full) begin
            m_rdy  = 1;
            m_byte = m_cb;
          end else begin
            m_req = 1; m_live = 1; m_maddr = full;
          end
        end
      end else if (m_rdy && e != 3) begin
        m_rdy = 0;
      end
    end
    if (m_req && !was_req) begin
      req_age = 0;
      if (rand_ack) ack_delay = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 13));
    end else if (m_req) begin
      req_age++;
    end
  endtask

  // Drive the ROM side, let the combinational outputs settle, compare with the model.
  task automatic settle();
    int e;
    bit got;
    logic [7:0] src;
    logic [3:0] x_out;
    bit x_oe;
    bit x_late;
    e = sync ? 0 : m_cnt;
    if (!reset && m_req && req_age >= ack_delay) begin
      mem_ack = 1'b1; mem_data = rom[m_maddr];
    end else if (stray_ack) begin
      mem_ack = 1'b1; mem_data = 8'h5A;
    end else begin
      mem_ack = 1'b0; mem_data = 8'($urandom);
    end
    #2;
    got    = m_rdy || (m_req && m_live && mem_ack && (e == 3 || e == 4));
    src    = m_rdy ? m_byte : mem_data;
    x_oe   = !reset && (e == 3 || e == 4);
    x_out  = 4'h0;
    if (x_oe && got) x_out = (e == 3) ? src[7:4] : src[3:0];
    x_late = !reset && e == 3 && !got && m_req;
    check("mem_req",    32'(mem_req),    32'(m_req));
    check("mem_addr",   32'(mem_addr),   32'(m_maddr));
    check("data_oe",    32'(data_oe),    32'(x_oe));
    check("data_out",   32'(data_out),   32'(x_out));
    check("fetch_late", 32'(fetch_late), 32'(x_late));
  endtask

  task automatic advance();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; sync = 1'b0; bus_valid = 1'b0; bus_in = 4'h0;
    mem_ack = 1'b0; mem_data = 8'h00; stray_ack = 1'b0;
    // First reset clock: DUT state is still unknown, so no comparison yet.
    model_step();
    @(posedge clock);
    @(negedge clock);
    for (int i = 1; i < n; i++) begin
      settle();
      advance();
    end
    reset = 1'b0;
  endtask

  // One instruction slot starting with sync; abort_at drops bus_valid at that cycle.
  task automatic run_slot(input logic [11:0] addr, input int delay, input int abort_at,
                          output logic [7:0] oe_mask, output logic [3:0] out3,
                          output logic [3:0] out4, output int late_n,
                          output bit req_seen, output logic [11:0] addr_seen);
    ack_delay = delay;
    oe_mask = 8'h00; out3 = 4'hx; out4 = 4'hx; late_n = 0; req_seen = 0; addr_seen = 12'hxxx;
    for (int k = 0; k < CPI; k++) begin
      reset = 1'b0;
      sync  = (k == 0);
      bus_valid = (k < 3) ? (k != abort_at) : 1'b0;
      bus_in = (k < 3) ? addr[4*k +: 4] : 4'($urandom);
      settle();
      oe_mask[k] = data_oe;
      if (k == 3) begin
        out3 = data_out;
        addr_seen = mem_addr;
      end
      if (k == 4) out4 = data_out;
      late_n += int'(fetch_late);
      if (mem_req) req_seen = 1;
      advance();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  logic [7:0]  oe_mask;
  logic [3:0]  out3;
  logic [3:0]  out4;
  int          late_n;
  bit          req_seen;
  logic [11:0] addr_seen;
  logic [7:0]  rb;
  int          e;

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[12'h1A3] = 8'hD5;
    model_reset();
    req_age = 0; ack_delay = 0; rand_ack = 0; stray_ack = 0;

    // Reset state is compared on the second reset clock inside do_reset.
    do_reset(2);

    // Minimum-latency fetch of 0x1A3 returning 0xD5.
    run_slot(12'h1A3, 0, -1, oe_mask, out3, out4, late_n, req_seen, addr_seen);
    check("fast_addr",  32'(addr_seen), 32'h1A3);
    check("fast_opr",   32'(out3),      32'hD);
    check("fast_opa",   32'(out4),      32'h5);
    check("fast_oe",    32'(oe_mask),   32'h18);
    check("fast_late",  32'(late_n),    32'd0);

    // Same address, ack only after cycle 4.
    do_reset(2);
    run_slot(12'h1A3, 4, -1, oe_mask, out3, out4, late_n, req_seen, addr_seen);
    check("late_opr",   32'(out3),      32'h0);
    check("late_opa",   32'(out4),      32'h0);
    check("late_pulse", 32'(late_n),    32'd1);
    check("late_oe",    32'(oe_mask),   32'h18);

    // Aborted capture right after the late slot: the late byte must not surface.
    run_slot(12'h1A3, 0, 1, oe_mask, out3, out4, late_n, req_seen, addr_seen);
    check("abort_req",  32'(req_seen),  32'd0);
    check("abort_opr",  32'(out3),      32'h0);
    check("abort_opa",  32'(out4),      32'h0);

    // Reset in the middle of a pending read, then a stale ack.
    do_reset(2);
    ack_delay = 1000;
    for (int k = 0; k < 4; k++) begin
      sync = (k == 0);
      bus_valid = (k < 3);
      bus_in = (k == 0) ? 4'h4 : (k == 1) ? 4'hB : (k == 2) ? 4'h2 : 4'h0;
      settle();
      if (k == 3) check("rst_req_before", 32'(mem_req), 32'd1);
      advance();
    end
    reset = 1'b1; sync = 1'b0; bus_valid = 1'b0;
    settle();
    advance();
    reset = 1'b0; stray_ack = 1'b1;
    settle();
    check("rst_req",  32'(mem_req),    32'd0);
    check("rst_addr", 32'(mem_addr),   32'h000);
    check("rst_oe",   32'(data_oe),    32'd0);
    check("rst_out",  32'(data_out),   32'h0);
    check("rst_late", 32'(fetch_late), 32'd0);
    advance();
    stray_ack = 1'b0;
    rb = rom[12'h2B4];
    run_slot(12'h2B4, 0, -1, oe_mask, out3, out4, late_n, req_seen, addr_seen);
    check("rst_next_addr", 32'(addr_seen), 32'h2B4);
    check("rst_next_opr",  32'(out3),      32'(rb[7:4]));
    check("rst_next_opa",  32'(out4),      32'(rb[3:0]));

    // sync arriving at cycle 5 realigns the slot and starts capture on that clock.
    do_reset(2);
    ack_delay = 0;
    for (int k = 0; k < 5; k++) begin
      sync = (k == 0); bus_valid = 1'b0; bus_in = 4'($urandom);
      settle();
      advance();
    end
    rb = rom[12'h7C2];
    run_slot(12'h7C2, 0, -1, oe_mask, out3, out4, late_n, req_seen, addr_seen);
    check("resync_oe",   32'(oe_mask),   32'h18);
    check("resync_addr", 32'(addr_seen), 32'h7C2);
    check("resync_opr",  32'(out3),      32'(rb[7:4]));
    check("resync_opa",  32'(out4),      32'(rb[3:0]));

`ifdef ROM_RESPONDER_CACHE_EN
    // Repeat fetch of 0x0FF is served from the cache.
    do_reset(2);
    rb = rom[12'h0FF];
    run_slot(12'h0FF, 0, -1, oe_mask, out3, out4, late_n, req_seen, addr_seen);
    check("cache_first_req", 32'(req_seen), 32'd1);
    check("cache_first_opr", 32'(out3),     32'(rb[7:4]));
    run_slot(12'h0FF, 1000, -1, oe_mask, out3, out4, late_n, req_seen, addr_seen);
    check("cache_hit_req",   32'(req_seen), 32'd0);
    check("cache_hit_opr",   32'(out3),     32'(rb[7:4]));
    check("cache_hit_opa",   32'(out4),     32'(rb[3:0]));
`endif

    // Randomized traffic: occasional resets, stray syncs, aborts and slow ROM.
    do_reset(2);
    rand_ack = 1;
    ack_delay = 0;
    repeat (3000) begin
      reset = ($urandom_range(0, 299) == 0);
      if (m_cnt == 0) sync = ($urandom_range(0, 1) == 1);
      else            sync = ($urandom_range(0, 23) == 0);
      e = sync ? 0 : m_cnt;
      bus_valid = (e <= 2) ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 1) == 1);
      // A narrow nibble alphabet makes repeated addresses common.
      bus_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1));
      settle();
      advance();
    end
    rand_ack = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_responder.md
ROM_RESPONDER -- requirements
Module: rom_responder

Interface
REQ-001 Parameter CYCLES_PER_INST, default 8, number of bus cycles per instruction slot; legal values 5..8.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sync  input  1  high marks the current clock as bus cycle 0.
REQ-005 bus_in  input  4  address nibble driven by the CPU program counter during cycles 0-2.
REQ-006 bus_valid  input  1  high when bus_in carries a valid address nibble.
REQ-007 data_out  output  4  instruction nibble returned to the CPU.
REQ-008 data_oe  output  1  high when data_out is being driven.
REQ-009 mem_addr  output  12  byte address presented to external ROM.
REQ-010 mem_req  output  1  ROM read request.
REQ-011 mem_ack  input  1  ROM read acknowledge; mem_data valid in the same clock.
REQ-012 mem_data  input  8  ROM byte; [7:4] = OPR, [3:0] = OPA.
REQ-013 fetch_late  output  1  one-clock pulse when the byte is not ready at cycle 3.

Function
REQ-014 Internal cycle counter: 3 bits, increments each clock, wraps from CYCLES_PER_INST-1 to 0; sync=1 forces the effective cycle to 0 for that clock, and the counter becomes 1 on the next clock.
REQ-015 FSM states: IDLE, CAPTURE, REQ, READY; IDLE->CAPTURE on cycle 0 with bus_valid=1.
REQ-016 In CAPTURE, cycle 0/1/2 latches bus_in into address bits [3:0]/[7:4]/[11:8].
REQ-017 bus_valid=0 during any of cycles 0-2: the fetch is aborted, FSM returns to IDLE, no request is issued.
REQ-018 The clock after cycle 2: mem_addr = assembled address, mem_req=1, FSM->REQ.
REQ-019 mem_req stays high and mem_addr stays stable until mem_ack=1; on the ack clock, mem_data is latched, mem_req=0 on the next clock, and FSM->READY.
REQ-020 Minimum latency: ack in the first REQ clock yields READY by cycle 4.
REQ-021 Cycle 3: data_oe=1, data_out=OPR if READY, else data_out=4'h0 and fetch_late pulses for one clock.
REQ-022 Cycle 4: data_oe=1, data_out=OPA if READY, else 4'h0 with no additional fetch_late pulse.
REQ-023 All other cycles: data_oe=0, data_out=4'h0.
REQ-024 After cycle 4, or on an ack arriving after cycle 4, the byte is discarded and FSM->IDLE.
REQ-025 sync=1 while in REQ: mem_req stays high until ack (handshake never withdrawn); the ack'd byte is discarded; no capture occurs until the ack.
REQ-026 sync=1 while in CAPTURE or READY: abandon and restart capture at cycle 0.

Reset
REQ-027 reset=1: counter=0, FSM=IDLE, mem_req=0, mem_addr=0, data_out=0, data_oe=0, fetch_late=0, latched byte=0, cache invalid.
REQ-028 Reset asserted while mem_req is high drops mem_req on the next clock; a subsequent ack from the old request is ignored.
REQ-029 reset has priority over sync and mem_ack in the same clock.

Configuration
REQ-030 With macro ROM_RESPONDER_CACHE_EN defined, a one-entry cache holds the last acknowledged address and byte; if the assembled address matches and the cache is valid, go directly to READY without asserting mem_req.
REQ-031 Without ROM_RESPONDER_CACHE_EN, every completed capture issues mem_req; no cache storage exists.

Verification
REQ-032 sync at clock 0; nibbles 4'h3, 4'hA, 4'h1; ack with 8'hD5 on the first REQ clock -> mem_addr=12'h1A3, cycle 3 data_out=4'hD, cycle 4 data_out=4'h5, data_oe high on exactly those two clocks.
REQ-033 Same address; ack delayed until after cycle 4 -> cycles 3/4 data_out=4'h0, fetch_late pulses once at cycle 3, late byte discarded.
REQ-034 bus_valid=0 at cycle 1 -> mem_req never asserts, data_out=4'h0 at cycles 3/4.
REQ-035 reset asserted mid-REQ, then ack -> all outputs at reset values, ack ignored, next sync starts a clean fetch.
REQ-036 CACHE_EN build: two consecutive fetches of 12'h0FF -> mem_req asserted only for the first, and the second returns the same byte at cycles 3/4.
REQ-037 sync asserted at cycle 5 of CYCLES_PER_INST=8 -> counter realigns, capture starts on that clock.
